pm_switch_ack_sequencer: RTL

PM_SWITCH_ACK_SEQUENCER -- requirements
Module: pm_switch_ack_sequencer

---
 rtl/pm_switch_ack_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pm_switch_ack_sequencer.sv
// Persist-switch ack sequencer: accepts a metadata word, optionally issues a persist request,
// waits for completion and emits ackCount indexed ack beats. Optional macro: PMSW_ACK_TIMEOUT_EN.
module pm_switch_ack_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meta_valid,
  output logic        meta_ready,
  input  logic [47:0] meta_output,
  output logic        pm_req_valid,
  input  logic        pm_req_ready,
  output logic [31:0] pm_req_addr,
  input  logic        pm_done,
  output logic        ack_valid,
  input  logic        ack_ready,
  output logic [31:0] ack_addr,
  output logic [7:0]  ack_idx,
  output logic        busy,
  output logic        err_op,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_PERSIST = 8'h01;
  localparam logic [7:0] OP_BYPASS  = 8'h02;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  idx_q, idx_d;
  logic        meta_ready_q, meta_ready_d;
  logic        pm_req_valid_q, pm_req_valid_d;
  logic        ack_valid_q, ack_valid_d;
  logic        busy_q, busy_d;
  logic        err_op_q, err_op_d;

`ifdef PMSW_ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_timeout_q, err_timeout_d;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    err_op_d = 1'b0;
`ifdef PMSW_ACK_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (meta_valid && meta_ready_q) begin
          addr_d  = meta_output[31:0];
          count_d = meta_output[47:40];
          case (meta_output[39:32])
            OP_PERSIST: state_d = ISSUE;
            OP_BYPASS: begin
              if (meta_output[47:40] != 8'd0) begin
                state_d = ACK;
                idx_d   = 8'd0;
              end else begin
                state_d = IDLE;
              end
            end
            OP_NOP:  state_d = IDLE;
            default: err_op_d = 1'b1;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // pm_done is deliberately not looked at here, even in the handshake cycle
        if (pm_req_ready) begin
          state_d = WAIT;
`ifdef PMSW_ACK_TIMEOUT_EN
          tmo_d = '0;
`endif
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (pm_done) begin
          if (count_q != 8'd0) begin
            state_d = ACK;
            idx_d   = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef PMSW_ACK_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      ACK: begin
        if (ack_ready) begin
          if (idx_q == count_q - 8'd1) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          state_d = ACK;
        end
      end
      default: state_d = IDLE;
    endcase

    meta_ready_d   = (state_d == IDLE);
    pm_req_valid_d = (state_d == ISSUE);
    ack_valid_d    = (state_d == ACK);
    busy_d         = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= 32'd0;
      count_q        <= 8'd0;
      idx_q          <= 8'd0;
      meta_ready_q   <= 1'b0;
      pm_req_valid_q <= 1'b0;
      ack_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_op_q       <= 1'b0;
`ifdef PMSW_ACK_TIMEOUT_EN
      tmo_q          <= '0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      meta_ready_q   <= meta_ready_d;
      pm_req_valid_q <= pm_req_valid_d;
      ack_valid_q    <= ack_valid_d;
      busy_q         <= busy_d;
      err_op_q       <= err_op_d;
`ifdef PMSW_ACK_TIMEOUT_EN
      tmo_q          <= tmo_d;
      err_timeout_q  <= err_timeout_d;
`endif
    end
  end

  assign meta_ready   = meta_ready_q;
  assign pm_req_valid = pm_req_valid_q;
  assign pm_req_addr  = addr_q;
  assign ack_valid    = ack_valid_q;
  assign ack_addr     = addr_q;
  assign ack_idx      = idx_q;
  assign busy         = busy_q;
  assign err_op       = err_op_q;
`ifdef PMSW_ACK_TIMEOUT_EN
  assign err_timeout  = err_timeout_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule
